// File: rtl/datapath_pkg.sv
// Shared datapath definitions: ALU opcodes, EX/WB writeback state encoding, default widths.
package datapath_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int REG_AW_DEF = 4;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_MOVE = 3'b010;
   localparam logic [2:0] ALU_SWAP = 3'b011;
   localparam logic [2:0] ALU_AND  = 3'b100;
   localparam logic [2:0] ALU_OR   = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      SW1  = 2'd2,
      SW2  = 2'd3
   } wb_state_t;

   function automatic logic is_arith(input logic [2:0] ctrl);
      return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
   endfunction

endpackage

// File: rtl/ex_wb_stage.sv
// EX->WB writeback stage: single register-file write port, swap split over two cycles.
// Optional overflow trap enabled by defining EX_WB_OVF_TRAP_EN.
//
// state | meaning
// IDLE  | no write this cycle
// WR    | writing result of a single-write instruction
// SW1   | swap: writing low half to rd, EX stalled
// SW2   | swap: writing high half to rs
module ex_wb_stage
   import datapath_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_valid,
   input  logic [2*DATA_W-1:0] ex_result,
   input  logic                ex_overflow,
   input  logic [2:0]          ex_alu_ctrl,
   input  logic                ex_reg_write,
   input  logic [REG_AW-1:0]   ex_rd,
   input  logic [REG_AW-1:0]   ex_rs,
   input  logic                flush,
   input  logic                ovf_clr,
   output logic                ex_stall,
   output logic                wb_en,
   output logic [REG_AW-1:0]   wb_addr,
   output logic [DATA_W-1:0]   wb_data,
   output logic                ovf_exc
);

   wb_state_t           state, state_nxt;
   logic                wb_en_nxt;
   logic [REG_AW-1:0]   wb_addr_nxt;
   logic [DATA_W-1:0]   wb_data_nxt;
   logic                ovf_nxt;
   logic                accept;
   logic                trap;
   logic                hold_we;
   logic [REG_AW-1:0]   hold_rs;
   logic [DATA_W-1:0]   hold_hi;
   logic                hold_load;

   assign ex_stall = (state == SW1);
   assign accept   = ex_valid && !ex_stall && !flush;

`ifdef EX_WB_OVF_TRAP_EN
   assign trap = accept && (ex_alu_ctrl != ALU_SWAP) && is_arith(ex_alu_ctrl) && ex_overflow;
   // Set wins over clear when both land on the same edge.
   assign ovf_nxt = trap ? 1'b1 : (ovf_clr ? 1'b0 : ovf_exc);
`else
   logic unused_ovf;
   assign trap       = 1'b0;
   assign ovf_nxt    = 1'b0;
   assign unused_ovf = ex_overflow ^ ovf_clr;
`endif

   always_comb begin
      state_nxt   = IDLE;
      wb_en_nxt   = 1'b0;
      wb_addr_nxt = wb_addr;
      wb_data_nxt = wb_data;
      hold_load   = 1'b0;
      if (state == SW1) begin
         // Second half of a swap is never cancelled; EX is stalled so nothing is accepted.
         state_nxt   = SW2;
         wb_en_nxt   = hold_we;
         wb_addr_nxt = hold_rs;
         wb_data_nxt = hold_hi;
      end else if (accept) begin
         wb_addr_nxt = ex_rd;
         wb_data_nxt = ex_result[DATA_W-1:0];
         if (ex_alu_ctrl == ALU_SWAP) begin
            state_nxt = SW1;
            wb_en_nxt = ex_reg_write;
            hold_load = 1'b1;
         end else begin
            state_nxt = WR;
            wb_en_nxt = ex_reg_write && !trap;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
         ovf_exc <= 1'b0;
         hold_we <= 1'b0;
         hold_rs <= '0;
         hold_hi <= '0;
      end else begin
         state   <= state_nxt;
         wb_en   <= wb_en_nxt;
         wb_addr <= wb_addr_nxt;
         wb_data <= wb_data_nxt;
         ovf_exc <= ovf_nxt;
         if (hold_load) begin
            hold_we <= ex_reg_write;
            hold_rs <= ex_rs;
            hold_hi <= ex_result[2*DATA_W-1:DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Scoreboard bench for ex_wb_stage: a write-queue reference model predicts each cycle's outputs.
module tb_ex_wb_stage;

   localparam int DW = 16;
   localparam int AW = 4;

`ifdef EX_WB_OVF_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_valid;
   logic [2*DW-1:0] ex_result;
   logic          ex_overflow;
   logic [2:0]    ex_alu_ctrl;
   logic          ex_reg_write;
   logic [AW-1:0] ex_rd, ex_rs;
   logic          flush, ovf_clr;
   logic          ex_stall, wb_en, ovf_exc;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;

   ex_wb_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
      .ex_overflow(ex_overflow), .ex_alu_ctrl(ex_alu_ctrl), .ex_reg_write(ex_reg_write),
      .ex_rd(ex_rd), .ex_rs(ex_rs), .flush(flush), .ovf_clr(ovf_clr),
      .ex_stall(ex_stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ovf_exc(ovf_exc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct packed {
      wr_t  w;
      logic stall;
      logic ovf;
   } exp_t;

   wr_t  wq[$];   // writes still owed to the register file, oldest first
   exp_t sb[$];   // expected per-cycle outputs awaiting the monitor
   logic ovf_m;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model advances at the edge and queues what the DUT must show.
   task automatic do_cycle(input logic v, input logic [31:0] res, input logic ov,
                           input logic [2:0] ctrl, input logic rw, input logic [AW-1:0] rd,
                           input logic [AW-1:0] rs, input logic fl, input logic clr);
      logic acc, trp;
      exp_t e;
      ex_valid = v; ex_result = res; ex_overflow = ov; ex_alu_ctrl = ctrl;
      ex_reg_write = rw; ex_rd = rd; ex_rs = rs; flush = fl; ovf_clr = clr;
      @(posedge clk);
      acc = v && (wq.size() == 0) && !fl;
      trp = 1'b0;
      if (acc) begin
         if (ctrl == 3'b011) begin
            wq.push_back('{en: rw, addr: rd, data: res[15:0]});
            wq.push_back('{en: rw, addr: rs, data: res[31:16]});
         end else begin
            trp = TRAP && ov && (ctrl == 3'b000 || ctrl == 3'b001);
            wq.push_back('{en: rw && !trp, addr: rd, data: res[15:0]});
         end
      end
      if (TRAP) ovf_m = trp ? 1'b1 : (clr ? 1'b0 : ovf_m);
      if (wq.size() > 0) e.w = wq.pop_front();
      else e.w = '{en: 1'b0, addr: '0, data: '0};
      e.stall = (wq.size() > 0);
      e.ovf   = ovf_m;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle();
      do_cycle(1'b0, 32'h0, 1'b0, 3'b000, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wb_en"},   {31'b0, wb_en},    32'h0);
      chk({tag, "_wb_addr"}, {28'b0, wb_addr},  32'h0);
      chk({tag, "_wb_data"}, {16'b0, wb_data},  32'h0);
      chk({tag, "_stall"},   {31'b0, ex_stall}, 32'h0);
      chk({tag, "_ovf"},     {31'b0, ovf_exc},  32'h0);
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk("wb_en",    {31'b0, wb_en},    {31'b0, mon_e.w.en});
         chk("ex_stall", {31'b0, ex_stall}, {31'b0, mon_e.stall});
         chk("ovf_exc",  {31'b0, ovf_exc},  {31'b0, mon_e.ovf});
         if (mon_e.w.en) begin
            chk("wb_addr", {28'b0, wb_addr}, {28'b0, mon_e.w.addr});
            chk("wb_data", {16'b0, wb_data}, {16'b0, mon_e.w.data});
         end
      end
   end

   initial begin
      rst = 1'b0; ovf_m = 1'b0;
      ex_valid = 0; ex_result = '0; ex_overflow = 0; ex_alu_ctrl = '0;
      ex_reg_write = 0; ex_rd = '0; ex_rs = '0; flush = 0; ovf_clr = 0;
      #3 chk_reset_outputs("por");
      @(negedge clk) rst = 1'b1;

      // ADD on the very first edge after reset release
      do_cycle(1, 32'h0000_0005, 0, 3'b000, 1, 4'd3, 4'd0, 0, 0);
      // SWAP, then a MOVE held through the stall
      do_cycle(1, 32'h1234_ABCD, 0, 3'b011, 1, 4'd1, 4'd2, 0, 0);
      do_cycle(1, 32'h0000_0042, 0, 3'b010, 1, 4'd4, 4'd0, 0, 0);
      do_cycle(1, 32'h0000_0042, 0, 3'b010, 1, 4'd4, 4'd0, 0, 0);
      // back-to-back MOVE r4, AND r5
      do_cycle(1, 32'h0000_1111, 0, 3'b010, 1, 4'd4, 4'd0, 0, 0);
      do_cycle(1, 32'h0000_2222, 0, 3'b100, 1, 4'd5, 4'd0, 0, 0);
      idle();
      // SUB overflow, sticky flag, clear, set+clear together
      do_cycle(1, 32'h0000_7777, 1, 3'b001, 1, 4'd6, 4'd0, 0, 0);
      idle(); idle();
      do_cycle(0, 32'h0, 0, 3'b000, 0, '0, '0, 0, 1);
      idle();
      do_cycle(1, 32'h0000_8888, 1, 3'b001, 1, 4'd6, 4'd0, 0, 1);
      idle();
      do_cycle(0, 32'h0, 0, 3'b000, 0, '0, '0, 0, 1);
      // overflow on a non-arithmetic op is ignored
      do_cycle(1, 32'h0000_3333, 1, 3'b101, 1, 4'd7, 4'd0, 0, 0);
      // flush in IDLE discards
      idle();
      do_cycle(1, 32'h0000_4444, 0, 3'b000, 1, 4'd8, 4'd0, 1, 0);
      idle();
      // flush during SW1 cannot cancel the SW2 write
      do_cycle(1, 32'hBEEF_CAFE, 0, 3'b011, 1, 4'd10, 4'd11, 0, 0);
      do_cycle(1, 32'h0000_5555, 0, 3'b000, 1, 4'd12, 4'd0, 1, 0);
      idle();
      // swap with rd == rs still writes both halves in order
      do_cycle(1, 32'h5A5A_A5A5, 0, 3'b011, 1, 4'd9, 4'd9, 0, 0);
      idle(); idle();

      // reset asserted while in SW1 abandons the swap
      do_cycle(1, 32'hDEAD_0001, 0, 3'b011, 1, 4'd13, 4'd14, 0, 0);
      #1 rst = 1'b0;
      #1 chk_reset_outputs("rst_sw1");
      wq.delete(); ovf_m = 1'b0;
      #1 rst = 1'b1;
      do_cycle(1, 32'h0000_0077, 0, 3'b000, 1, 4'd7, 4'd0, 0, 0);
      idle(); idle();

      for (int i = 0; i < 400; i++) begin
         do_cycle($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 3) == 0,
                  3'($urandom_range(0, 7)), $urandom_range(0, 5) != 0,
                  4'($urandom), 4'($urandom), $urandom_range(0, 6) == 0,
                  $urandom_range(0, 4) == 0);
      end
      idle(); idle();
      @(negedge clk);
      chk("sb_drained", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
